// File: rtl/shadow_chain_collector_if.sv
// Word readout bus from the chain collector FIFO to the host readout logic.
interface shadow_chain_collector_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned ID_W   = 2
);
    localparam int unsigned BITS_W = $clog2(WORD_W) + 1;

    logic [WORD_W-1:0] word_out;
    logic [ID_W-1:0]   word_id;
    logic [BITS_W-1:0] word_bits;
    logic              word_last;
    logic              word_vld;
    logic              word_rdy;

    modport master (
        output word_out, word_id, word_bits, word_last, word_vld,
        input  word_rdy
    );

    modport slave (
        input  word_out, word_id, word_bits, word_last, word_vld,
        output word_rdy
    );
endinterface

// File: rtl/shadow_chain_collector.sv
// Collects serial shadow-chain dumps into tagged words and queues them
// through a round-robin arbiter into a show-ahead FIFO.
module shadow_chain_collector #(
    parameter int unsigned CHAINS     = 3,
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ID_W       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [CHAINS-1:0]        dump_en,
    input  logic [CHAINS-1:0]        chains_in,
    input  logic [CHAINS-1:0]        chains_in_vld,
    input  logic [CHAINS-1:0]        chains_in_done,
    output logic                     busy,
    output logic                     overflow,
    shadow_chain_collector_if.master word_bus
);
    localparam int unsigned CNT_W = $clog2(WORD_W) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DUMP, COLLECT, DRAIN} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [CNT_W-1:0]  bits;
        logic              last;
    } entry_t;

    state_t state, state_nxt;

    logic [WORD_W-1:0] shreg     [CHAINS];
    logic [WORD_W-1:0] shreg_nxt [CHAINS];
    logic [CNT_W-1:0]  cnt       [CHAINS];
    logic [CNT_W-1:0]  cnt_nxt   [CHAINS];
    logic [WORD_W-1:0] full_data     [CHAINS];
    logic [WORD_W-1:0] full_data_nxt [CHAINS];
    logic [WORD_W-1:0] term_data     [CHAINS];
    logic [WORD_W-1:0] term_data_nxt [CHAINS];
    logic [CNT_W-1:0]  term_bits     [CHAINS];
    logic [CNT_W-1:0]  term_bits_nxt [CHAINS];
    logic [CHAINS-1:0] fin, fin_nxt;
    logic [CHAINS-1:0] full_vld, full_vld_nxt;
    logic [CHAINS-1:0] term_vld, term_vld_nxt;
    logic              overflow_nxt;

    logic [WORD_W-1:0] asm_data [CHAINS];
    logic [CNT_W-1:0]  asm_cnt  [CHAINS];
    logic [CHAINS-1:0] asm_full;

    logic [CHAINS-1:0] grant_full, grant_term;
    logic              push, found;
    entry_t            push_entry;
    logic [ID_W-1:0]   last_grant, last_grant_nxt, sel;

    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, pop, can_push;

    // Next chain index after 'last', stepping 'step' positions round the ring.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] last,
                                               input int unsigned     step);
        logic [ID_W:0] sum;
        sum = {1'b0, last} + (ID_W+1)'(step);
        if (sum >= (ID_W+1)'(CHAINS))
            sum = sum - (ID_W+1)'(CHAINS);
        return ID_W'(sum);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DUMP;
            DUMP:    state_nxt = COLLECT;
            COLLECT: if ((&fin) && !(|full_vld) && !(|term_vld)) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register contents after absorbing this cycle's bit, if any.
    always_comb begin
        asm_full = '0;
        for (int c = 0; c < CHAINS; c++) begin
            asm_data[c] = shreg[c];
            asm_cnt[c]  = cnt[c];
            if (chains_in_vld[c]) begin
                asm_data[c] = shreg[c] | (WORD_W'(chains_in[c]) << cnt[c]);
                asm_cnt[c]  = cnt[c] + CNT_W'(1);
            end
            asm_full[c] = (asm_cnt[c] == CNT_W'(WORD_W));
        end
    end

    // Per-chain deserialiser and pending word/terminator slots.
    always_comb begin
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        full_data_nxt = full_data;
        term_data_nxt = term_data;
        term_bits_nxt = term_bits;
        fin_nxt       = fin;
        full_vld_nxt  = full_vld & ~grant_full;
        term_vld_nxt  = term_vld & ~grant_term;
        overflow_nxt  = overflow;
        if (state == DUMP) begin
            for (int c = 0; c < CHAINS; c++) begin
                shreg_nxt[c]     = '0;
                cnt_nxt[c]       = '0;
                full_data_nxt[c] = '0;
                term_data_nxt[c] = '0;
                term_bits_nxt[c] = '0;
            end
            fin_nxt      = '0;
            full_vld_nxt = '0;
            term_vld_nxt = '0;
            overflow_nxt = 1'b0;
        end else if (state == COLLECT) begin
            for (int c = 0; c < CHAINS; c++) begin
                if (!fin[c]) begin
                    if (asm_full[c]) begin
                        shreg_nxt[c] = '0;
                        cnt_nxt[c]   = '0;
                        // A slot being granted this cycle is free for the new word.
                        if (full_vld[c] && !grant_full[c]) begin
                            overflow_nxt = 1'b1;
                        end else begin
                            full_vld_nxt[c]  = 1'b1;
                            full_data_nxt[c] = asm_data[c];
                        end
                    end else begin
                        shreg_nxt[c] = asm_data[c];
                        cnt_nxt[c]   = asm_cnt[c];
                    end
                    if (chains_in_done[c]) begin
                        fin_nxt[c]       = 1'b1;
                        term_vld_nxt[c]  = 1'b1;
                        term_data_nxt[c] = asm_full[c] ? '0 : asm_data[c];
                        term_bits_nxt[c] = asm_full[c] ? '0 : asm_cnt[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHAINS; c++) begin
                shreg[c]     <= '0;
                cnt[c]       <= '0;
                full_data[c] <= '0;
                term_data[c] <= '0;
                term_bits[c] <= '0;
            end
            fin      <= '0;
            full_vld <= '0;
            term_vld <= '0;
            overflow <= 1'b0;
        end else begin
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            full_data <= full_data_nxt;
            term_data <= term_data_nxt;
            term_bits <= term_bits_nxt;
            fin       <= fin_nxt;
            full_vld  <= full_vld_nxt;
            term_vld  <= term_vld_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // Round-robin push arbiter; full words outrank a chain's terminator.
    always_comb begin
        grant_full     = '0;
        grant_term     = '0;
        push           = 1'b0;
        found          = 1'b0;
        push_entry     = '0;
        sel            = '0;
        last_grant_nxt = last_grant;
        if (state == COLLECT && can_push) begin
            for (int unsigned i = 1; i <= CHAINS; i++) begin
                sel = rr_idx(last_grant, i);
                if (!found && (full_vld[sel] || term_vld[sel])) begin
                    found          = 1'b1;
                    push           = 1'b1;
                    last_grant_nxt = sel;
                    if (full_vld[sel]) begin
                        grant_full[sel] = 1'b1;
                        push_entry = '{data: full_data[sel], id: sel,
                                       bits: CNT_W'(WORD_W), last: 1'b0};
                    end else begin
                        grant_term[sel] = 1'b1;
                        push_entry = '{data: term_data[sel], id: sel,
                                       bits: term_bits[sel], last: 1'b1};
                    end
                end
            end
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop      = !empty && word_bus.word_rdy;
    assign can_push = !full || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= ID_W'(CHAINS - 1);
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // Outputs flagged from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_en <= '0;
            busy    <= 1'b0;
        end else begin
            dump_en <= {CHAINS{state_nxt == DUMP}};
            busy    <= (state_nxt != IDLE);
        end
    end

    assign head                = mem[rd_ptr[PTR_W-1:0]];
    assign word_bus.word_vld   = !empty;
    assign word_bus.word_out   = empty ? '0 : head.data;
    assign word_bus.word_id    = empty ? '0 : head.id;
    assign word_bus.word_bits  = empty ? '0 : head.bits;
    assign word_bus.word_last  = empty ? 1'b0 : head.last;
endmodule

// File: tb/tb_shadow_chain_collector.sv
// Directed bench for shadow_chain_collector: expected words are queued as
// stimulus is driven and compared in order as the FIFO hands them out.
module tb_shadow_chain_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] dump_en;
    logic [2:0] chains_in;
    logic [2:0] chains_in_vld;
    logic [2:0] chains_in_done;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [14:0] sb[$];

    shadow_chain_collector_if #(.WORD_W(8), .ID_W(2)) bus ();

    shadow_chain_collector #(
        .CHAINS(3), .WORD_W(8), .FIFO_DEPTH(8), .ID_W(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dump_en        (dump_en),
        .chains_in      (chains_in),
        .chains_in_vld  (chains_in_vld),
        .chains_in_done (chains_in_done),
        .busy           (busy),
        .overflow       (overflow),
        .word_bus       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ent(input logic [1:0] id, input logic [7:0] data,
                                        input logic [3:0] bits, input logic last);
        return {id, data, bits, last};
    endfunction

    function automatic logic [7:0] val(input int c, input int k);
        return 8'((c + 1) * 16 + k);
    endfunction

    // Scoreboard: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.word_vld && bus.word_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_word",
                      32'({bus.word_id, bus.word_out, bus.word_bits, bus.word_last}), 32'h7fff_ffff);
            end else begin
                check("word", 32'({bus.word_id, bus.word_out, bus.word_bits, bus.word_last}),
                      32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("dump_en_pulse", 32'(dump_en), 32'h7);
        check("busy_in_dump", 32'(busy), 32'h1);
        tick();
        check("dump_en_one_cycle", 32'(dump_en), 32'h0);
    endtask

    task automatic send_bits(input logic [2:0] mask, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [7:0] w2, input int n);
        for (int i = 0; i < n; i++) begin
            chains_in_vld = mask;
            chains_in     = {w2[i], w1[i], w0[i]};
            tick();
        end
        chains_in_vld = '0;
        chains_in     = '0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, 32'(busy), 32'h0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        chains_in = '0;
        chains_in_vld = '0;
        chains_in_done = '0;
        bus.word_rdy = 1'b0;
        tick();
        tick();
        check("rst_dump_en", 32'(dump_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_word_vld", 32'(bus.word_vld), 32'h0);
        rst = 1'b0;
        tick();

        // Session 1: full words on chains 0/1, then chain 2 word after others finish.
        bus.word_rdy = 1'b1;
        start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored", 32'(dump_en), 32'h0);
        tick();
        check("restart_ignored2", 32'(dump_en), 32'h0);
        sb.push_back(ent(2'd0, 8'hFC, 4'd8, 1'b0));
        sb.push_back(ent(2'd1, 8'hEB, 4'd8, 1'b0));
        sb.push_back(ent(2'd0, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd1, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd2, 8'hDA, 4'd8, 1'b0));
        sb.push_back(ent(2'd2, 8'h00, 4'd0, 1'b1));
        send_bits(3'b011, 8'hFC, 8'hEB, 8'h00, 8);
        chains_in_done = 3'b011;
        repeat (3) tick();
        check("busy_collect", 32'(busy), 32'h1);
        send_bits(3'b100, 8'h00, 8'h00, 8'hDA, 8);
        chains_in_done = 3'b111;
        wait_idle("s1_idle");
        chains_in_done = '0;
        tick();

        // Session 2: partial 5-bit word on chain 0.
        start_session();
        sb.push_back(ent(2'd1, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd2, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd0, 8'h0D, 4'd5, 1'b1));
        chains_in_done = 3'b010;
        tick();
        chains_in_done = 3'b110;
        tick();
        send_bits(3'b001, 8'h0D, 8'h00, 8'h00, 5);
        chains_in_done = 3'b111;
        wait_idle("s2_idle");
        chains_in_done = '0;
        tick();

        // Session 3: eighth bit arrives together with done.
        start_session();
        sb.push_back(ent(2'd1, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd2, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd0, 8'hA5, 4'd8, 1'b0));
        sb.push_back(ent(2'd0, 8'h00, 4'd0, 1'b1));
        chains_in_done = 3'b110;
        tick();
        tick();
        send_bits(3'b001, 8'hA5, 8'h00, 8'h00, 7);
        chains_in_vld = 3'b001;
        chains_in = 3'b001;
        chains_in_done = 3'b111;
        tick();
        chains_in_vld = '0;
        chains_in = '0;
        wait_idle("s3_idle");
        chains_in_done = '0;
        tick();

        // Session 4: stalled consumer, FIFO and slots fill, later words drop.
        bus.word_rdy = 1'b0;
        start_session();
        sb.push_back(ent(2'd1, val(1, 1), 4'd8, 1'b0));
        sb.push_back(ent(2'd2, val(2, 1), 4'd8, 1'b0));
        sb.push_back(ent(2'd0, val(0, 1), 4'd8, 1'b0));
        sb.push_back(ent(2'd1, val(1, 2), 4'd8, 1'b0));
        sb.push_back(ent(2'd2, val(2, 2), 4'd8, 1'b0));
        sb.push_back(ent(2'd0, val(0, 2), 4'd8, 1'b0));
        sb.push_back(ent(2'd1, val(1, 3), 4'd8, 1'b0));
        sb.push_back(ent(2'd2, val(2, 3), 4'd8, 1'b0));
        sb.push_back(ent(2'd0, val(0, 3), 4'd8, 1'b0));
        sb.push_back(ent(2'd1, val(1, 4), 4'd8, 1'b0));
        sb.push_back(ent(2'd2, val(2, 4), 4'd8, 1'b0));
        sb.push_back(ent(2'd0, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd1, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd2, 8'h00, 4'd0, 1'b1));
        for (int k = 1; k <= 5; k++)
            send_bits(3'b111, val(0, k), val(1, k), val(2, k), 8);
        tick();
        tick();
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_word_vld", 32'(bus.word_vld), 32'h1);
        check("ovf_head", 32'({bus.word_id, bus.word_out, bus.word_bits, bus.word_last}),
              32'(ent(2'd1, val(1, 1), 4'd8, 1'b0)));
        chains_in_done = 3'b111;
        repeat (3) tick();
        bus.word_rdy = 1'b1;
        wait_idle("s4_idle");
        check("ovf_sticky", 32'(overflow), 32'h1);
        chains_in_done = '0;
        tick();

        // Session 5: reset while words sit in the FIFO.
        bus.word_rdy = 1'b0;
        start_session();
        check("ovf_cleared_by_dump", 32'(overflow), 32'h0);
        send_bits(3'b111, 8'h11, 8'h22, 8'h33, 8);
        repeat (4) tick();
        check("s5_word_vld", 32'(bus.word_vld), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_word_vld", 32'(bus.word_vld), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        check("midrst_dump_en", 32'(dump_en), 32'h0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_dump_en", 32'(dump_en), 32'h0);

        // Session 6: normal session after reset, arbitration restarts at chain 0.
        bus.word_rdy = 1'b1;
        start_session();
        sb.push_back(ent(2'd0, 8'h5A, 4'd8, 1'b0));
        sb.push_back(ent(2'd1, 8'h3C, 4'd8, 1'b0));
        sb.push_back(ent(2'd2, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd0, 8'h00, 4'd0, 1'b1));
        sb.push_back(ent(2'd1, 8'h00, 4'd0, 1'b1));
        send_bits(3'b011, 8'h5A, 8'h3C, 8'h00, 8);
        chains_in_done = 3'b111;
        wait_idle("s6_idle");
        chains_in_done = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shadow_chain_collector.md
Name: shadow_chain_collector

Overview:
Downstream consumer of the shadow-capture block's serial dump outputs.
- Issues the one-cycle dump request.
- Deserialises each chain's bit stream (data/valid/done per chain) into WORD_W-bit words, tagged with chain id, bit count and last flag.
- Round-robin arbitrates the words into one FIFO and presents them on a valid/ready interface to the host readout logic.

Parameters:
CHAINS, 3, number of serial chains consumed (matches upstream CHAINS_OUT)
WORD_W, 8, bits per assembled word
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=2
ID_W, 2, chain-id width; 2**ID_W >= CHAINS

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begin a dump/collect session
dump_en  out  CHAINS  one-cycle all-ones pulse to upstream dump_en
chains_in  in  CHAINS  serial data bit per chain
chains_in_vld  in  CHAINS  bit valid per chain
chains_in_done  in  CHAINS  level; chain finished (held high until session ends)
word_out  out  WORD_W  assembled word, LSB = first bit received, unused MSBs zero
word_id  out  ID_W  source chain index
word_bits  out  $clog2(WORD_W)+1  number of valid bits in word_out (0..WORD_W)
word_last  out  1  final word of that chain
word_vld  out  1  FIFO head valid
word_rdy  in  1  consumer accepts head when word_vld&&word_rdy
busy  out  1  session in progress
overflow  out  1  sticky; a word was dropped

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, per-chain counters/pending/finished flags cleared, overflow cleared. Reset mid-session aborts everything immediately; no dump_en glitch on release.
- FSM states:
  - IDLE: start=1 -> DUMP.
  - DUMP, one cycle: dump_en = all ones, busy=1, clear per-chain state -> COLLECT.
  - COLLECT: when every chain is finished and no pending words remain -> DRAIN.
  - DRAIN: FIFO empty -> IDLE.
- busy=1 in DUMP/COLLECT/DRAIN. start outside IDLE is ignored.
- Per chain c, COLLECT only, while not finished[c]:
  - vld[c]=1: chains_in[c] written to bit cnt[c] of shreg[c]; cnt[c]++.
  - cnt reaches WORD_W: load full-word pending slot {data, bits=WORD_W, last=0}; cnt and shreg clear.
  - done[c]=1, first cycle seen: finished[c] set; terminator pending set with {shreg, bits=cnt (0 allowed), last=1}. Any vld bit in the same cycle is included first.
  - If that bit completes a word, the full word goes in the word slot (bits=WORD_W) and the terminator has bits=0. Both emitted, full word first.
  - After finished[c], vld/data on c are ignored.
- Arbiter:
  - One push per cycle when FIFO not full.
  - Round-robin across chains, starting after the last granted chain; after reset, chain 0 first.
  - Within a chain, the full-word slot has priority over the terminator slot.
- Overflow: a word completes while that chain's full-word slot is still occupied -> new word dropped, overflow=1 (sticky until rst or next DUMP).
- FIFO:
  - Show-ahead; word_vld = !empty.
  - Pop on word_vld&&word_rdy.
  - Push and pop in the same cycle allowed when full (pop frees the slot).
  - Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- Latency: final bit sampled at edge N -> pending at N -> FIFO push at edge N+1 -> word_vld high after edge N+1 (uncontended, FIFO not full).

Test Plan:
- Reset, start pulse -> dump_en=3'b111 for exactly one cycle, busy=1. A second start while busy -> no further dump_en.
- Chains 0/1 send 0xFC/0xEB LSB-first (vld=3'b011, 8 cycles). Then done=3'b011. Chain 2 sends 0xDA, then done=3'b111. word_rdy=1 -> expected stream:
  - (id0, 0xFC, 8, 0), (id1, 0xEB, 8, 0)
  - (id0, 0x00, 0, 1), (id1, 0x00, 0, 1)
  - (id2, 0xDA, 8, 0), (id2, 0x00, 0, 1)
  - then busy->0.
- Chain 0 sends bits 1,0,1,1,0 then done -> (id0, 0x0D, 5, last=1). Same-cycle vld with 8th bit plus done -> full word then bits=0 terminator.
- word_rdy=0 while 3 chains stream 40 bits each -> FIFO holds 8 entries, pending slots fill, further completed words set overflow=1. Releasing word_rdy drains exactly the stored entries in order.
- Assert rst mid-COLLECT with 3 words in FIFO -> word_vld=0, busy=0, overflow=0 immediately. A new session completes normally.
